// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose: sequential instruction fetcher with a 2-entry prefetch buffer.
//   The PC drives a combinational instruction memory. Each fetched byte is
//   pushed into the buffer together with its address. The control unit
//   consumes the head entry with a valid/ready handshake. A redirect
//   flushes the buffer and restarts fetch at a new address.
//
// Optional feature (macro IFETCH_HALT_EN):
//   When defined, fetching 8'h00 pushes that entry, freezes the PC on its
//   address and enters HALT. HALT is left only by a redirect.
//   When undefined, 8'h00 is an ordinary instruction and halted is tied 0.
//
// Parameters:
//   RESET_PC    - PC value loaded on reset
//   DEPTH       - prefetch buffer entries (only 2 is supported)
//
// Ports:
//   clk          in   clock, all state changes on its rising edge
//   rst_n        in   asynchronous active-low reset
//   imem_addr    out  instruction memory address (the PC)
//   imem_data    in   instruction memory data, valid in the same cycle
//   instr        out  head-of-buffer instruction (0 when buffer empty)
//   instr_pc     out  fetch address of instr (0 when buffer empty)
//   instr_valid  out  buffer non-empty
//   instr_ready  in   consumer accepts the head entry this cycle
//   redirect     in   flush and restart fetch at redirect_pc
//   redirect_pc  in   new fetch address
//   halted       out  fetch stopped in HALT state
//   fifo_count   out  number of occupied buffer entries (0..2)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [3:0] RESET_PC = 4'h0,
  parameter int         DEPTH    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic [7:0] instr,
  output logic [3:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       redirect,
  input  logic [3:0] redirect_pc,
  output logic       halted,
  output logic [1:0] fifo_count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, wr_ptr_q;
  logic [11:0] buf_q [2];            // each entry is {fetch pc, instruction}

  logic        pop;
  logic        push;
  logic        halt_hit;
  logic [11:0] head;

  // A handshake in the same cycle as a redirect is discarded with the flush.
  assign pop  = instr_valid & instr_ready & ~redirect;
  // A pop frees the head slot at this edge, so a full buffer still accepts.
  assign push = (state_q == RUN) & ~redirect & ((count_q != FULL) | pop);

`ifdef IFETCH_HALT_EN
  assign halt_hit = push & (imem_data == 8'h00);
  assign halted   = (state_q == HALT);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (redirect) begin
      state_d = RUN;
      pc_d    = redirect_pc;
      count_d = 2'd0;
    end else begin
      if (halt_hit) begin
        state_d = HALT;              // PC stays on the halt instruction
      end else if (push) begin
        pc_d = pc_q + 4'd1;          // wraps 4'hF -> 4'h0
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      if (redirect) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        rd_ptr_q <= rd_ptr_q ^ pop;
        wr_ptr_q <= wr_ptr_q ^ push;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= 12'h000;
      buf_q[1] <= 12'h000;
    end else if (push) begin
      buf_q[wr_ptr_q] <= {pc_q, imem_data};
    end
  end

  assign head        = buf_q[rd_ptr_q];
  assign instr_valid = (count_q != 2'd0);
  assign instr       = instr_valid ? head[7:0]  : 8'h00;
  assign instr_pc    = instr_valid ? head[11:8] : 4'h0;
  assign imem_addr   = pc_q;
  assign fifo_count  = count_q;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 4'h0: PC value loaded on reset.
REQ-002 Parameter DEPTH, default 2: prefetch buffer entries; only the value 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_addr  output  4  instruction memory address; equals the PC register.
REQ-006 imem_data  input  8  instruction memory read data; combinational and valid in the same cycle as imem_addr.
REQ-007 instr  output  8  head-of-buffer instruction to the control unit.
REQ-008 instr_pc  output  4  address from which instr was fetched.
REQ-009 instr_valid  output  1  buffer non-empty; instr and instr_pc are meaningful.
REQ-010 instr_ready  input  1  control unit accepts the head entry this cycle.
REQ-011 redirect  input  1  one-cycle request to flush and restart fetch.
REQ-012 redirect_pc  input  4  new fetch address, sampled when redirect=1.
REQ-013 halted  output  1  fetch is stopped in HALT state.
REQ-014 fifo_count  output  2  number of occupied buffer entries (0..2).

Function
REQ-015 States SHALL be RUN and HALT.
- RUN->HALT on a halt push (REQ-021).
- HALT->RUN only on redirect.
- Reset enters RUN.
REQ-016 Push condition, per cycle: state RUN, redirect=0, and (fifo_count<2 or pop this cycle).
- Action: write {PC, imem_data} at the tail.
- PC <= PC+1, modulo 16; 4'hF wraps to 4'h0.
REQ-017 Pop occurs when instr_valid=1 and instr_ready=1; the head advances at the clock edge.
REQ-018 Simultaneous push and pop SHALL leave fifo_count unchanged.
- This holds both when full (throughput 1 instruction/cycle) and when count=1.
REQ-019 Empty buffer: a pushed entry appears on instr/instr_valid the cycle after the push; there is no bypass.
REQ-020 Redirect has priority over push and pop.
- Buffer is flushed: fifo_count <= 0, instr_valid <= 0.
- PC <= redirect_pc.
- State <= RUN.
- No push that cycle; a concurrent pop handshake is discarded.
- First fetch from redirect_pc occurs in the next cycle.
REQ-021 With IFETCH_HALT_EN defined, pushing imem_data==8'h00 SHALL:
- push the entry;
- not increment PC;
- enter HALT.
REQ-022 In HALT there is no fetching. Existing entries still drain via pop. imem_addr holds the halt instruction's address.
REQ-023 instr and instr_pc SHALL hold their value while instr_valid=1 and instr_ready=0.
REQ-024 When instr_valid=0, instr and instr_pc SHALL read 0.
REQ-025 halted SHALL be 1 exactly while in HALT state.

Reset
REQ-026 On rst_n=0 at any time, including mid-fetch, asynchronously:
- PC=RESET_PC
- fifo_count=0
- instr_valid=0
- instr=8'h00, instr_pc=4'h0
- halted=0
- state=RUN
REQ-027 The first push SHALL occur on the first posedge clk after rst_n deasserts.

Configuration
REQ-028 Macro IFETCH_HALT_EN SHALL control halt detection.
- Defined: REQ-021/REQ-022 apply.
- Undefined: 8'h00 is fetched as an ordinary instruction, halted is tied 0, and HALT is unreachable.

Verification
REQ-029 Memory holds 01,C1,13,03 at addresses 1..4, RESET_PC=1, instr_ready=1 constant -> instr sequence 01,C1,13,03 on consecutive cycles, with instr_pc 1,2,3,4.
REQ-030 instr_ready=0 for 5 cycles -> fifo_count saturates at 2, PC stops at RESET_PC+2, and instr holds 01. Raising ready -> 01 then C1 with no loss or duplicate.
REQ-031 Fetch at PC=4'hF, then continue -> next instr_pc=4'h0 (wrap).
REQ-032 redirect=1 with redirect_pc=4'h3 while fifo_count=2 and instr_ready=1 -> next cycle instr_valid=0 and fifo_count=0; the following cycle instr=13 with instr_pc=3.
REQ-033 IFETCH_HALT_EN defined, addr 5 holds 00 -> 00 delivered with instr_pc=5, then halted=1 and imem_addr stays 5. Redirect to 1 -> halted=0 and 01 fetched again. Without the macro -> halted stays 0 and fetch continues past 5.
REQ-034 Assert rst_n=0 mid-stream with fifo_count=2 -> outputs immediately take REQ-026 values, with no clock edge required.
